mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one single-ported unified memory between the CPU's instruction-fetch port and its load/store port. Each requester gets a valid/ready handshake. The arbiter serialises the two requesters onto a fixed-latency memory. It sits between the `CPU` core and the memory model in the single-cycle design; the core stalls while its `*_ready` is low.

## Interface
- `LATENCY`, default 1: cycles from `mem_en` to valid `mem_rdata`; must be ≥1.
- `MAX_D_BURST`, default 2: maximum consecutive data grants while `i_req` waits.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `i_req` in 1: fetch request.
- `i_addr` in 32: fetch byte address.
- `i_ready` out 1: one-cycle completion pulse for the fetch.
- `i_rdata` out 32: fetched word.
- `d_req` in 1: load/store request.
- `d_we` in 1: 1 = store.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_wstrb` in 4: store byte enables.
- `d_ready` out 1: one-cycle completion pulse for the data access.
- `d_rdata` out 32: load data.
- `mem_en` out 1: one-cycle access strobe.
- `mem_we` out 1: write enable.
- `mem_addr` out 32: access address.
- `mem_wdata` out 32: write data.
- `mem_wstrb` out 4: write byte enables.
- `mem_rdata` in 32: read data, valid `LATENCY` cycles after `mem_en`.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. One access is outstanding at a time.
- IDLE:
  - No request: stay in IDLE.
  - Any request: latch owner, address, we, wdata and wstrb into registers; go to ISSUE.
- Owner selection:
  - Only one requester asserted: that requester wins.
  - Both asserted: data wins, unless `burst_cnt == MAX_D_BURST`, in which case fetch wins.
- `burst_cnt`:
  - Increments on a data grant while `i_req` = 1.
  - Clears on any fetch grant, or on a data grant while `i_req` = 0.
  - Saturates at `MAX_D_BURST`.
- ISSUE:
  - `mem_en` = 1; `mem_*` driven from the latched registers.
  - Fetches drive `mem_we` = 0 and `mem_wstrb` = 0.
  - Next state: WAIT if `LATENCY` > 1, else DONE.
- WAIT: down-counter runs `LATENCY`−1 cycles; go to DONE when it expires.
- Response capture: on the edge entering DONE, capture `mem_rdata` into the owner's rdata register.
  - Stores do not update `d_rdata`.
  - The non-owner's rdata register is unchanged.
- DONE: owner's `*_ready` = 1 for exactly one cycle; next state is always IDLE.
- Requester rule: hold `req` and all payload stable until `ready`. In the cycle after `ready`, either drop `req` or present a new request. A `req` still high in IDLE is a new request.
- Payload changes while not in IDLE are ignored, because payload is latched.
- `mem_*` outputs are 0 in every state except ISSUE.
- No address alignment checks; `mem_addr` is passed through unchanged.

## Timing
- Reset values:
  - State = IDLE.
  - All `*_ready`, `mem_en`, `mem_we`, `mem_wstrb`, `busy` = 0.
  - `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata` = 0.
  - `burst_cnt` = 0; latency counter = 0.
- Request sampled in IDLE at cycle 0:
  - `mem_en` in cycle 1.
  - `ready` in cycle `LATENCY`+1.
  - Back in IDLE in cycle `LATENCY`+2.
- Per-access occupancy is `LATENCY`+2 cycles. Peak throughput is one access per `LATENCY`+2 cycles.
- `*_rdata` is valid from the `ready` cycle and holds until the next read for that port.
- `reset` asserted in any state:
  - Next cycle is IDLE with reset values.
  - The in-flight memory response is discarded; no `ready` is issued.
  - Requesters must re-request.
- `i_req` and `d_req` rising in the same cycle: arbitration per Operation. The loser is served immediately after the winner's DONE → IDLE, provided its `req` is still held.

## Structure
- Shared package `mem_arb_pkg`:
  - State enum: IDLE, ISSUE, WAIT, DONE.
  - Owner encoding: OWN_I = 0, OWN_D = 1.
  - Constant `XLEN` = 32.
- No sub-module. Counter and mux are inline; the RTL is a single module.

## Test plan
- Fetch only: `LATENCY` = 1, `i_req` with `i_addr` = 0x0000_0010, memory returns 0x0000_0013 → `mem_en` in cycle 1, `i_ready` in cycle 2, `i_rdata` = 0x0000_0013.
- Store then load, `LATENCY` = 3:
  - Store `d_addr` = 0x100, `d_wdata` = 0xDEAD_BEEF, `d_wstrb` = 0xF → `mem_we` = 1 in cycle 1, `d_ready` in cycle 4, `d_rdata` unchanged.
  - Load from 0x100 → `d_rdata` = 0xDEAD_BEEF.
- Contention, `MAX_D_BURST` = 2: `i_req` and `d_req` held continuously → grant order D, D, I, D, D, I; no `i_ready` starvation beyond 2 data accesses.
- Reset mid-WAIT, `LATENCY` = 4: assert `reset` in cycle 2 → cycle 3 is IDLE, no `ready` pulse, all outputs 0; re-request completes normally.
- Payload change while busy: alter `d_addr` in cycle 2 → `mem_addr` in cycle 1 reflects the original address, and the captured result belongs to the original access.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter:
// FSM state, owner encoding and the latched memory request payload.
package mem_arb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Serialises the CPU fetch and load/store ports onto one fixed-latency,
// single-ported memory; one access outstanding, bounded data bursts.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned MAX_D_BURST = 2
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              i_req,
  input  logic [XLEN-1:0]   i_addr,
  output logic              i_ready,
  output logic [XLEN-1:0]   i_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_ready,
  output logic [XLEN-1:0]   d_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic [XLEN-1:0]   mem_rdata,

  output logic              busy
);

  localparam int unsigned LAT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned BURST_W = (MAX_D_BURST > 0) ? $clog2(MAX_D_BURST + 1) : 1;

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                we_q, we_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  mem_req_t            mem_q, mem_d;
  logic                mem_en_q, mem_en_d;
  logic                i_ready_q, i_ready_d;
  logic                d_ready_q, d_ready_d;
  logic [XLEN-1:0]     i_rdata_q, i_rdata_d;
  logic [XLEN-1:0]     d_rdata_q, d_rdata_d;
  logic                busy_q, busy_d;
  logic                data_win;

  // Next-state, arbitration, payload latch and response capture.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    burst_d   = burst_q;
    lat_d     = lat_q;
    mem_d     = '0;
    mem_en_d  = 1'b0;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    data_win  = d_req && (!i_req || (burst_q != BURST_W'(MAX_D_BURST)));

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d  = ISSUE;
          mem_en_d = 1'b1;
          if (data_win) begin
            owner_d     = OWN_D;
            we_d        = d_we;
            mem_d.we    = d_we;
            mem_d.addr  = d_addr;
            mem_d.wdata = d_wdata;
            mem_d.wstrb = d_wstrb;
            // A data win with i_req pending implies burst_q < MAX_D_BURST.
            burst_d = i_req ? (burst_q + BURST_W'(1)) : '0;
          end else begin
            owner_d    = OWN_I;
            we_d       = 1'b0;
            mem_d.addr = i_addr;
            burst_d    = '0;
          end
        end
      end
      ISSUE: begin
        if (LATENCY > 1) begin
          state_d = WAIT;
          lat_d   = LAT_W'(LATENCY - 1);
        end else begin
          state_d = DONE;
        end
      end
      WAIT: begin
        if (lat_q <= LAT_W'(1)) begin
          state_d = DONE;
          lat_d   = '0;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // DONE is only reachable from ISSUE/WAIT, so this fires on entry only.
    if (state_d == DONE) begin
      if (owner_q == OWN_I) begin
        i_ready_d = 1'b1;
        i_rdata_d = mem_rdata;
      end else begin
        d_ready_d = 1'b1;
        if (!we_q) begin
          d_rdata_d = mem_rdata;
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      we_q      <= 1'b0;
      burst_q   <= '0;
      lat_q     <= '0;
      mem_q     <= '0;
      mem_en_q  <= 1'b0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      burst_q   <= burst_d;
      lat_q     <= lat_d;
      mem_q     <= mem_d;
      mem_en_q  <= mem_en_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      busy_q    <= busy_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_q.we;
  assign mem_addr  = mem_q.addr;
  assign mem_wdata = mem_q.wdata;
  assign mem_wstrb = mem_q.wstrb;
  assign i_ready   = i_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;

endmodule
